// File: rtl/cv32e40n_apu_responder.sv
// cv32e40n_apu_responder: in-order APU request queue; ADD executes locally, LOAD/STORE go out over OBI.
module cv32e40n_apu_responder #(
  parameter int NARGS = 3,
  parameter int WOP = 6,
  parameter int NDSFLAGS = 15,
  parameter int NUSFLAGS = 5,
  parameter int DEPTH = 4,
  parameter int LATENCY = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NARGS*32-1:0]   apu_operands_i,
  input  logic [WOP-1:0]        apu_op_i,
  input  logic [NDSFLAGS-1:0]   apu_flags_i,
  input  logic                  apu_req_i,
  output logic                  apu_gnt_o,
  output logic                  apu_rvalid_o,
  output logic [31:0]           apu_result_o,
  output logic [NUSFLAGS-1:0]   apu_flags_o,
  output logic                  mem_master_sel,
  output logic                  data_req_o,
  input  logic                  data_gnt_i,
  input  logic                  data_rvalid_i,
  output logic                  data_we_o,
  output logic [3:0]            data_be_o,
  output logic [31:0]           data_addr_o,
  output logic [31:0]           data_wdata_o,
  input  logic [31:0]           data_rdata_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [2:0] {IDLE, EXEC, MREQ, MWAIT, RESP} state_t;
  state_t state, state_n;
  logic [1:0] q_op [DEPTH];
  logic [31:0] q_a [DEPTH];
  logic [31:0] q_b [DEPTH];
  logic [AW:0] wp, rp;
  logic [1:0] op, h_op;
  logic [31:0] a, b, res, h_a, h_b;
  logic ill;
  logic [CW-1:0] cnt;
  logic empty, push, pop, unused;
  assign empty = wp == rp;
  assign apu_gnt_o = !(wp[AW-1:0] == rp[AW-1:0] && wp[AW] != rp[AW]);
  assign push = apu_req_i && apu_gnt_o;
  assign pop = state == IDLE && !empty;
  assign h_op = q_op[rp[AW-1:0]];
  assign h_a = q_a[rp[AW-1:0]];
  assign h_b = q_b[rp[AW-1:0]];
  assign unused = ^{apu_operands_i, apu_op_i, apu_flags_i};
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
    if (push) begin
      q_op[wp[AW-1:0]] <= apu_op_i[1:0];
      q_a[wp[AW-1:0]] <= apu_operands_i[31:0];
      q_b[wp[AW-1:0]] <= apu_operands_i[63:32];
    end
  end
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!empty) state_n = (h_op == 2'd1 || h_op == 2'd2) ? MREQ : EXEC;
      EXEC:    if (cnt == '0) state_n = RESP;
      MREQ:    if (data_gnt_i) state_n = MWAIT;
      MWAIT:   if (data_rvalid_i) state_n = RESP;
      default: state_n = IDLE;
    endcase
  end
  // ADD and illegal results are known at pop; memory results overwrite on rvalid
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op <= '0;
      a <= '0;
      b <= '0;
      res <= '0;
      ill <= 1'b0;
      cnt <= '0;
    end else begin
      if (pop) begin
        op <= h_op;
        a <= h_a;
        b <= h_b;
        res <= h_op == 2'd0 ? h_a + h_b : '0;
        ill <= h_op == 2'd3;
        cnt <= CW'(LATENCY - 1);
      end else if (state == EXEC && cnt != '0) cnt <= cnt - 1'b1;
      if (state == MWAIT && data_rvalid_i) res <= op == 2'd1 ? data_rdata_i : '0;
    end
  end
  assign mem_master_sel = state == MREQ || state == MWAIT;
  assign data_req_o = state == MREQ;
  assign data_we_o = data_req_o && op == 2'd2;
  assign data_be_o = {4{data_req_o}};
  assign data_addr_o = data_req_o ? a : '0;
  assign data_wdata_o = data_we_o ? b : '0;
  assign apu_rvalid_o = state == RESP;
  assign apu_result_o = apu_rvalid_o ? res : '0;
  assign apu_flags_o = NUSFLAGS'(apu_rvalid_o && ill);
endmodule

// File: tb/tb_cv32e40n_apu_responder.sv
// tb_cv32e40n_apu_responder: directed plus random APU traffic against an in-order result model and a memory model.
module tb_cv32e40n_apu_responder;
  localparam int NARGS = 3, WOP = 6, NDSFLAGS = 15, NUSFLAGS = 5, DEPTH = 4, LATENCY = 2;
  logic clk = 0;
  logic rst_i = 1;
  logic [NARGS*32-1:0] apu_operands_i = '0;
  logic [WOP-1:0] apu_op_i = '0;
  logic [NDSFLAGS-1:0] apu_flags_i = '0;
  logic apu_req_i = 0;
  logic apu_gnt_o, apu_rvalid_o, mem_master_sel, data_req_o, data_we_o;
  logic [31:0] apu_result_o, data_addr_o, data_wdata_o;
  logic [NUSFLAGS-1:0] apu_flags_o;
  logic [3:0] data_be_o;
  logic data_gnt_i = 0, data_rvalid_i = 0;
  logic [31:0] data_rdata_i = '0;
  cv32e40n_apu_responder #(.NARGS(NARGS), .WOP(WOP), .NDSFLAGS(NDSFLAGS), .NUSFLAGS(NUSFLAGS),
    .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i(clk), .rst_i(rst_i), .apu_operands_i(apu_operands_i), .apu_op_i(apu_op_i),
    .apu_flags_i(apu_flags_i), .apu_req_i(apu_req_i), .apu_gnt_o(apu_gnt_o),
    .apu_rvalid_o(apu_rvalid_o), .apu_result_o(apu_result_o), .apu_flags_o(apu_flags_o),
    .mem_master_sel(mem_master_sel), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_we_o(data_we_o), .data_be_o(data_be_o),
    .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o), .data_rdata_i(data_rdata_i));
  always #5 clk = ~clk;
  typedef struct {logic [31:0] res; logic [31:0] fl;} exp_t;
  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata;} mreq_t;
  exp_t eq[$];
  mreq_t mq[$];
  logic [31:0] shadow [logic [31:0]];
  logic [31:0] bmem [logic [31:0]];
  int vectors = 0, errs = 0;
  bit mem_hold = 0, spur = 0, pend = 0, prev_rv = 0;
  int gmin = 0, gmax = 0, rmin = 0, rmax = 0, gcnt = 0, gtgt = 0, rwait = 0;
  logic [31:0] pdata;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] dflt(input logic [31:0] addr);
    return {addr[15:0], ~addr[31:16]} ^ 32'h3C96_5AA5;
  endfunction
  // reference: each request's response is fully determined, in order, at the moment it is granted
  task automatic model_push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.fl = op == 2'd3 ? 32'd1 : 32'd0;
    e.res = op == 2'd0 ? a + b : 32'd0;
    if (op == 2'd1) begin
      e.res = shadow.exists(a) ? shadow[a] : dflt(a);
      mq.push_back('{1'b0, a, 32'd0});
    end
    if (op == 2'd2) begin
      shadow[a] = b;
      mq.push_back('{1'b1, a, b});
    end
    eq.push_back(e);
  endtask
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    apu_req_i = 1;
    apu_op_i = WOP'($urandom);
    apu_op_i[1:0] = op;
    apu_flags_i = NDSFLAGS'($urandom);
    apu_operands_i = {$urandom, b, a};
    while (!apu_gnt_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("issue_gnt", apu_gnt_o, 1);
    if (apu_gnt_o) model_push(op, a, b);
    @(posedge clk);
    #1 apu_req_i = 0;
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while (eq.size() != 0 && n < lim) begin
      @(negedge clk);
      #1 n++;
    end
    chk("drain", eq.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  always @(negedge clk) begin
    mreq_t m;
    data_gnt_i = 0;
    data_rvalid_i = 0;
    if (rst_i) begin
      pend = 0;
      gcnt = 0;
    end else if (pend) begin
      if (rwait == 0) begin
        data_rvalid_i = 1;
        data_rdata_i = pdata;
        pend = 0;
      end else rwait--;
    end else begin
      if (spur && $urandom_range(0, 7) == 0) begin
        data_rvalid_i = 1;
        data_rdata_i = $urandom;
      end
      if (data_req_o === 1'b1 && !mem_hold) begin
        if (gcnt == 0) gtgt = $urandom_range(gmax, gmin);
        if (gcnt == gtgt) begin
          data_gnt_i = 1;
          gcnt = 0;
          if (mq.size() == 0) chk("mem_unexp", 1, 0);
          else begin
            m = mq.pop_front();
            chk("mem_we", data_we_o, m.we);
            chk("mem_addr", data_addr_o, m.addr);
            chk("mem_wdata", data_wdata_o, m.wdata);
            chk("mem_be", data_be_o, 4'hF);
          end
          pdata = data_we_o ? $urandom : (bmem.exists(data_addr_o) ? bmem[data_addr_o] : dflt(data_addr_o));
          if (data_we_o) bmem[data_addr_o] = data_wdata_o;
          pend = 1;
          rwait = $urandom_range(rmax, rmin);
        end else gcnt++;
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!rst_i) begin
      if (apu_rvalid_o) begin
        chk("rv_pulse", prev_rv, 0);
        if (eq.size() == 0) chk("rv_unexp", 1, 0);
        else begin
          e = eq.pop_front();
          chk("result", apu_result_o, e.res);
          chk("flags", apu_flags_o, e.fl);
        end
      end else chk("idle_result", apu_result_o, 0);
    end
    prev_rv = apu_rvalid_o;
  end
  initial begin
    bit seen, done, got;
    int nreq, rcyc, n;
    logic [1:0] op;
    shadow[32'h100] = 32'hDEADBEEF;
    bmem[32'h100] = 32'hDEADBEEF;
    repeat (2) @(negedge clk);
    rst_i = 0;
    #1;
    chk("rst_gnt", apu_gnt_o, 1);
    chk("rst_rvalid", apu_rvalid_o, 0);
    chk("rst_req", data_req_o, 0);
    chk("rst_msel", mem_master_sel, 0);
    chk("rst_flags", apu_flags_o, 0);
    issue(2'd0, 32'd5, 32'd7);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      chk("add_lat", apu_rvalid_o, k == 4);
      chk("add_gnt", apu_gnt_o, 1);
    end
    issue(2'd0, 32'hFFFF_FFFF, 32'd2);
    drain(20);
    gmin = 3; gmax = 3; rmin = 1; rmax = 1;
    issue(2'd1, 32'h100, $urandom);
    seen = 0; done = 0; got = 0; nreq = 0; rcyc = -100;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      #1;
      if (data_req_o) begin
        seen = 1;
        nreq++;
        chk("ld_addr", data_addr_o, 32'h100);
        chk("ld_we", data_we_o, 0);
        chk("ld_be", data_be_o, 4'hF);
      end
      chk("ld_msel", mem_master_sel, seen && !done);
      if (apu_rvalid_o) begin
        got = 1;
        chk("ld_rv_lat", i - rcyc, 1);
      end
      if (data_rvalid_i) begin
        done = 1;
        rcyc = i;
      end
    end
    chk("ld_done", got, 1);
    chk("ld_nreq", nreq, 4);
    drain(20);
    gmin = 0; gmax = 2; rmin = 0; rmax = 2;
    issue(2'd2, 32'h200, 32'hA5A5_A5A5);
    issue(2'd1, 32'h200, 32'd0);
    drain(40);
    mem_hold = 1;
    issue(2'd1, 32'h104, 32'd0);
    for (int i = 0; i < DEPTH; i++) issue(2'($urandom), 32'h100 + 4 * $urandom_range(0, 7), $urandom);
    @(negedge clk);
    apu_req_i = 1;
    repeat (3) begin
      #1 chk("full_gnt", apu_gnt_o, 0);
      @(negedge clk);
    end
    apu_req_i = 0;
    mem_hold = 0;
    drain(200);
    issue(2'd3, $urandom, $urandom);
    drain(20);
    mem_hold = 1;
    issue(2'd1, 32'h108, 32'd0);
    issue(2'd0, 32'd1, 32'd2);
    n = 0;
    while (!data_req_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rst_mreq_seen", data_req_o, 1);
    @(negedge clk);
    rst_i = 1;
    eq.delete();
    mq.delete();
    @(negedge clk);
    #1 chk("rst_req_drop", data_req_o, 0);
    @(negedge clk);
    rst_i = 0;
    #1;
    chk("rst_mid_gnt", apu_gnt_o, 1);
    chk("rst_mid_msel", mem_master_sel, 0);
    mem_hold = 0;
    repeat (8) @(negedge clk);
    #1 chk("rst_mid_idle", data_req_o, 0);
    spur = 1;
    for (int i = 0; i < 80; i++) begin
      op = 2'($urandom);
      issue(op, (op == 2'd1 || op == 2'd2) ? 32'h100 + 4 * $urandom_range(0, 7) : $urandom, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(2000);
    spur = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/cv32e40n_apu_responder.md
Name: cv32e40n_apu_responder

Overview:
Parametrised APU-side responder that replaces the fixed-latency dummy in cv32e40n accelerator bring-up. It accepts APU requests into an in-order queue and executes each one. ALU ops add operand 0 and operand 1 with programmable latency. Memory ops perform a real OBI-style load or store on the data memory port, with mem_master_sel steering the shared memory bus. It sits between the core's APU interface and the data-memory mux.

Parameters:
NARGS, 3, number of 32-bit APU operands (APU_NARGS_CPU)
WOP, 6, APU op width (APU_WOP_CPU)
NDSFLAGS, 15, downstream flag width (APU_NDSFLAGS_CPU)
NUSFLAGS, 5, upstream flag width (APU_NUSFLAGS_CPU)
DEPTH, 4, request queue entries; power of two, >=2
LATENCY, 2, ALU execute cycles; >=1

Ports:
clk_i  in  1  clock; all state on rising edge
rst_i  in  1  synchronous active-high reset
apu_operands_i  in  NARGS*32  request operands; op0 = addr/src A, op1 = src B/store data
apu_op_i  in  WOP  [1:0] opcode: 0 ADD, 1 LOAD, 2 STORE, 3 illegal; upper bits ignored
apu_flags_i  in  NDSFLAGS  accepted, unused
apu_req_i  in  1  request valid
apu_gnt_o  out  1  request accepted this cycle
apu_rvalid_o  out  1  one-cycle response pulse
apu_result_o  out  32  response data, valid with rvalid
apu_flags_o  out  NUSFLAGS  bit0 = illegal op; other bits 0
mem_master_sel  out  1  1 while this block owns the data port
data_req_o  out  1  OBI request
data_gnt_i  in  1  OBI grant
data_rvalid_i  in  1  OBI response valid
data_we_o  out  1  1 = store
data_be_o  out  4  byte enables
data_addr_o  out  32  address
data_wdata_o  out  32  store data
data_rdata_i  in  32  load data

Behaviour:
- Reset (rst_i high at an edge): queue empty, FSM IDLE, counter 0. All outputs 0 except apu_gnt_o=1, which is combinational from an empty queue. Reset mid-transaction aborts it: data_req_o drops the next cycle, pending entries are discarded, no rvalid.
- Queue: stores {op[1:0], op0, op1}. apu_gnt_o = !full; push when apu_req_i && apu_gnt_o. Pop only in IDLE when non-empty. Full and pop in the same cycle: gnt stays 0 (no bypass). Pointers are log2(DEPTH)+1 bits and wrap naturally.
- FSM states: IDLE, EXEC, MREQ, MWAIT, RESP.
  - IDLE, queue non-empty: pop the head into working registers. ADD or illegal -> EXEC with cnt=LATENCY-1. LOAD/STORE -> MREQ.
  - EXEC: cnt==0 -> RESP, else cnt--. ADD result = op0+op1 mod 2^32. Illegal result = 0 with flag0=1.
  - MREQ: data_req_o=1, addr=op0, be=4'hF, we=(STORE), wdata=op1 (wdata is 0 for LOAD). All held stable until data_gnt_i; on gnt -> MWAIT.
  - MWAIT: on data_rvalid_i, capture rdata (LOAD) or 0 (STORE) -> RESP. A data_rvalid_i arriving outside MWAIT is ignored.
  - RESP: apu_rvalid_o=1 with registered result/flags for exactly one cycle -> IDLE. Outside RESP, result and flags read 0.
- mem_master_sel = 1 in MREQ and MWAIT, else 0. It depends only on state, never on apu_op_i.
- Latency (grant at cycle T, queue empty, FSM idle): ADD rvalid at T+2+LATENCY. Memory rvalid at cycle R+1, where R is the cycle data_rvalid_i is seen.
- Responses are strictly in request order. There is no backpressure on rvalid.

Test Plan:
- Reset then ADD op0=5, op1=7, LATENCY=2, granted at T: rvalid only at T+4, result 12, flags 0; gnt=1 throughout.
- ADD 0xFFFFFFFF+2: result 0x00000001 (wrap), flags 0.
- LOAD op0=0x100, gnt delayed 3 cycles, rvalid 2 cycles after gnt, rdata 0xDEADBEEF: req/addr/we=0/be=F held stable until gnt; mem_master_sel high from MREQ to rvalid; apu result 0xDEADBEEF one cycle after data_rvalid.
- STORE op0=0x200, op1=0xA5A5A5A5: we=1, wdata 0xA5A5A5A5; response result 0.
- Back-to-back requests with memory gnt held low: after DEPTH grants apu_gnt_o=0; releasing gnt drains all entries; responses arrive in order, each rvalid a single-cycle pulse.
- Op=3 gives result 0, flag0=1. rst_i asserted during MREQ: data_req_o=0 next cycle, queue empty, gnt=1, no rvalid.
